// File: rtl/mc_scatter_sequencer.sv
// mc_scatter_sequencer
//   Feeds a row of NUM_MC multicast controllers. Words (tag, value) from the global buffer are
//   queued in a small FIFO. A programming sequence loads each controller's tag_id, one per
//   cycle. In RUN, the FIFO head drives the shared multicast bus. The head advances only when
//   every controller whose tag matches is ready. A word that matches no controller is dropped
//   and counted in a saturating counter.
// Ports
//   clk, rstb                       clock, async active-low reset
//   prog_start, prog_tag_ids        start pulse and per-controller tag_ids for programming
//   prog_done                       one-cycle pulse when programming completes
//   in_valid/in_ready/in_tag/in_value  upstream word interface into the FIFO
//   mc_program, mc_tag_id           one-hot program strobe and shared tag_id bus
//   mc_enable, mc_tag, mc_value     shared multicast bus (head of FIFO)
//   mc_ready, mc_match              per-controller ready and tag-match feedback
//   busy, drop_count                activity flag and count of unmatched words
module mc_scatter_sequencer #(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned BITWIDTH      = 16,
  parameter int unsigned NUM_MC        = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            prog_start,
  input  logic [NUM_MC*ADDRESS_WIDTH-1:0] prog_tag_ids,
  output logic                            prog_done,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ADDRESS_WIDTH-1:0]        in_tag,
  input  logic [BITWIDTH-1:0]             in_value,
  output logic [NUM_MC-1:0]               mc_program,
  output logic [ADDRESS_WIDTH-1:0]        mc_tag_id,
  output logic                            mc_enable,
  output logic [ADDRESS_WIDTH-1:0]        mc_tag,
  output logic [BITWIDTH-1:0]             mc_value,
  input  logic [NUM_MC-1:0]               mc_ready,
  input  logic [NUM_MC-1:0]               mc_match,
  output logic                            busy,
  output logic [CNT_WIDTH-1:0]            drop_count
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned IdxW  = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;
  localparam int unsigned WordW = ADDRESS_WIDTH + BITWIDTH;

  typedef enum logic [1:0] {StIdle, StProg, StRun} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         index_q, index_d;
  logic [NUM_MC-1:0]       mc_program_q, mc_program_d;
  logic [ADDRESS_WIDTH-1:0] mc_tag_id_q, mc_tag_id_d;
  logic                    prog_done_q, prog_done_d;
  logic [CNT_WIDTH-1:0]    drop_count_q, drop_count_d;
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WordW-1:0]        mem_q [FIFO_DEPTH];
  logic [WordW-1:0]        mem_d [FIFO_DEPTH];

  logic             empty, full, push, pop, deliver, drop;
  logic [WordW-1:0] head;
  logic [IdxW-1:0]  idx_next;
  int unsigned      sel_base;

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    in_ready  = !full;
    push      = in_valid & !full;
    head      = mem_q[rd_ptr_q[PtrW-1:0]];
    mc_enable = (state_q == StRun) & !empty;
    mc_tag    = mc_enable ? head[WordW-1:BITWIDTH] : '0;
    mc_value  = mc_enable ? head[BITWIDTH-1:0] : '0;
    // Every matching controller must be ready; non-matching ready lines are masked off.
    deliver   = mc_enable & (|mc_match) & (&(mc_ready | ~mc_match));
    drop      = mc_enable & ~(|mc_match);
    pop       = deliver | drop;
    busy      = (state_q == StProg) | !empty;
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[PtrW-1:0]] = {in_tag, in_value};
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    drop_count_d = (drop && (drop_count_q != {CNT_WIDTH{1'b1}})) ? drop_count_q + 1'b1
                                                                  : drop_count_q;
  end

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    mc_program_d = '0;
    mc_tag_id_d  = '0;
    prog_done_d  = 1'b0;
    idx_next     = index_q + 1'b1;
    sel_base     = 32'(idx_next) * ADDRESS_WIDTH;
    unique case (state_q)
      StIdle, StRun: begin
        if (prog_start) begin
          state_d      = StProg;
          index_d      = '0;
          mc_program_d = NUM_MC'(1);
          mc_tag_id_d  = prog_tag_ids[ADDRESS_WIDTH-1:0];
        end
      end
      StProg: begin
        // Strobe k is already on the outputs; prepare k+1 or finish.
        if (index_q == IdxW'(NUM_MC - 1)) begin
          state_d     = StRun;
          index_d     = '0;
          prog_done_d = 1'b1;
        end else begin
          index_d      = idx_next;
          mc_program_d = NUM_MC'(1) << idx_next;
          mc_tag_id_d  = prog_tag_ids[sel_base +: ADDRESS_WIDTH];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= StIdle;
      index_q      <= '0;
      mc_program_q <= '0;
      mc_tag_id_q  <= '0;
      prog_done_q  <= 1'b0;
      drop_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      mc_program_q <= mc_program_d;
      mc_tag_id_q  <= mc_tag_id_d;
      prog_done_q  <= prog_done_d;
      drop_count_q <= drop_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
    end
  end

  assign mc_program = mc_program_q;
  assign mc_tag_id  = mc_tag_id_q;
  assign prog_done  = prog_done_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/mc_scatter_sequencer.md
Name: mc_scatter_sequencer

Overview:
- Upstream feeder for a row of NUM_MC multicast_controller instances.
- Buffers (tag, value) words from the global buffer in a small FIFO.
- Runs a programming sequence that loads each controller's tag_id, one controller per cycle.
- In RUN state, drives the shared multicast bus and advances one word only when every tag-matching controller is ready. Words that match no controller are dropped and counted.

Parameters:
ADDRESS_WIDTH, 4, tag / tag_id width
BITWIDTH, 16, value width on the multicast bus
NUM_MC, 4, number of downstream multicast controllers
FIFO_DEPTH, 4, input FIFO entries; must be a power of 2, at least 2
CNT_WIDTH, 8, drop counter width

Ports:
clk  in  1  clock, rising edge
rstb  in  1  asynchronous active-low reset
prog_start  in  1  single-cycle pulse; starts the programming sequence
prog_tag_ids  in  NUM_MC*ADDRESS_WIDTH  tag_id for controller i in slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]; sampled during PROG
prog_done  out  1  one-cycle pulse on the PROG->RUN transition
in_valid  in  1  upstream word valid
in_ready  out  1  FIFO can accept a word
in_tag  in  ADDRESS_WIDTH  destination tag
in_value  in  BITWIDTH  payload
mc_program  out  NUM_MC  one-hot program strobe, one per controller
mc_tag_id  out  ADDRESS_WIDTH  shared tag_id bus used while programming
mc_enable  out  1  bus word valid (enable to all controllers)
mc_tag  out  ADDRESS_WIDTH  shared tag bus
mc_value  out  BITWIDTH  shared value bus
mc_ready  in  NUM_MC  per-controller unit_ready
mc_match  in  NUM_MC  per-controller combinational (mc_tag == tag_id)
busy  out  1  high when state is PROG, or FIFO is non-empty
drop_count  out  CNT_WIDTH  count of words that matched no controller; saturating

Behaviour:
- Reset (rstb low, asynchronous): state = IDLE, FIFO empty, index = 0, drop_count = 0.
  - All outputs 0 except in_ready = 1.
  - Reset mid-sequence discards FIFO contents and the programming progress.
- States: IDLE, PROG, RUN.
  - IDLE --prog_start--> PROG
  - RUN --prog_start--> PROG
  - PROG --index==NUM_MC-1--> RUN
  - prog_start is ignored while already in PROG.
- PROG, registered outputs per cycle:
  - On each cycle k = 0..NUM_MC-1: mc_program = 1<<k, mc_tag_id = prog_tag_ids slice k.
  - Sequence lasts exactly NUM_MC cycles.
  - Cycle after the last strobe: mc_program = 0, prog_done = 1 for one cycle, state = RUN.
  - mc_enable = 0 throughout PROG; mc_match and mc_ready are ignored.
- FIFO:
  - push = in_valid & in_ready; in_ready = !full in every state. No bypass, no push when full.
  - A pushed word appears at the head no earlier than the next cycle.
  - Simultaneous push and pop: occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- RUN bus:
  - mc_enable = (state == RUN) & !empty.
  - mc_tag and mc_value = FIFO head, combinational. They are 0 when mc_enable = 0.
  - deliver = mc_enable & (|mc_match) & (&(mc_ready | ~mc_match)). Head pops at the clock edge; the controllers latch the value on that same edge.
  - drop = mc_enable & ~(|mc_match). Head pops; drop_count increments and saturates at all-ones.
  - Otherwise the head holds and mc_tag/mc_value stay stable (stall).
- In IDLE the FIFO fills but nothing is issued.
- Order is strictly FIFO; no reordering, no skipping past a stalled head.
- busy = (state == PROG) | !empty.

Test Plan:
- Program: reset, prog_tag_ids = {4'd3,4'd2,4'd1,4'd0} (ctrl3..ctrl0), pulse prog_start -> mc_program 0001, 0010, 0100, 1000 on consecutive cycles; mc_tag_id 0, 1, 2, 3; prog_done pulses on the fifth cycle; state RUN.
- Deliver: push (tag 2, value 512), mc_match = 0100, mc_ready = 1111 -> mc_enable high with tag 2 / value 512 for one cycle; FIFO empty after; busy drops.
- Stall: push (tag 3, 257), mc_match = 1000, mc_ready = 0111 for 3 cycles then 1111 -> bus holds 3/257 for 4 cycles; pop only on the 4th cycle.
- Multicast: mc_match = 0110, mc_ready = 0100 -> no pop; set mc_ready = 0110 -> pop. Ready of a non-matching controller has no effect.
- Drop and saturation: with CNT_WIDTH = 2, push 5 words with mc_match = 0000 -> each pops in one cycle; drop_count 1, 2, 3, 3, 3.
- Full, reset and reprogram:
  - Fill 4 words in IDLE -> in_ready = 0, no mc_enable.
  - Assert prog_start -> PROG, FIFO held; afterwards the 4 words drain in order.
  - Assert rstb low mid-drain -> FIFO empty, state IDLE, drop_count 0, all outputs 0.
